// File: rtl/sh7034_intc_if.sv
// rtl/sh7034_intc_if.sv - IBUS register port bundle for the SH7034 interrupt controller
interface sh7034_intc_if;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DI;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;

  modport master (
    output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DO, IBUS_BUSY, IBUS_ACT
  );

  modport slave (
    input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DO, IBUS_BUSY, IBUS_ACT
  );
endinterface

// File: rtl/sh7034_intc.sv
// rtl/sh7034_intc.sv - SH7034 interrupt controller: IPRA-IPRE/ICR, priority arbitration, CPU request
// Optional IRQ edge mode: SH7034_INTC_EDGE_EN
module sh7034_intc (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic        NMI_N,
  input  logic [7:0]  IRQ_N,
  input  logic [11:0] ONCHIP_IRQ,
  input  logic [3:0]  CPU_IMASK,
  input  logic        INT_ACK,
  output logic        INT_REQ,
  output logic [3:0]  INT_LVL,
  output logic [7:0]  INT_VEC,
  sh7034_intc_if.slave ibus
);

`ifdef SH7034_INTC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  localparam int NSRC = 21;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACKW} state_t;

  state_t      state;
  logic [15:0] ipra, iprb, iprc, iprd;
  logic [11:0] ipre_hi;
  logic        icr_nmie;
  logic [7:0]  icr_irqs;
  logic        nmi_s1, nmi_s2, nmi_lat;
  logic [7:0]  irq_s1, irq_s2, irq_lat;
  logic [4:0]  pend_idx;

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] d,
                                             input logic [1:0] be);
    return {be[1] ? d[15:8] : old_v[15:8], be[0] ? d[7:0] : old_v[7:0]};
  endfunction

  logic        sel, wr;
  logic [1:0]  hi_be, lo_be;
  logic [31:0] rd_word;
  logic [15:0] icr_rd;

  assign sel   = ibus.IBUS_REQ && (ibus.IBUS_A[27:4] == 24'h5FFFF8) && (ibus.IBUS_A[3:2] != 2'b00);
  assign wr    = sel && ibus.IBUS_WE && CE_R;
  assign hi_be = ibus.IBUS_A[1] ? 2'b00 : ibus.IBUS_BA[3:2];
  assign lo_be = ibus.IBUS_A[1] ? ibus.IBUS_BA[1:0] : 2'b00;
  assign icr_rd = {nmi_s2, 6'd0, icr_nmie, icr_irqs};

  assign ibus.IBUS_BUSY = 1'b0;
  assign ibus.IBUS_ACT  = sel;

  always_comb begin
    rd_word = 32'h0;
    case (ibus.IBUS_A[3:2])
      2'b01:   rd_word = {ipra, iprb};
      2'b10:   rd_word = {iprc, iprd};
      2'b11:   rd_word = {ipre_hi, 4'h0, icr_rd};
      default: rd_word = 32'h0;
    endcase
  end

  // Edges are seen one stage early (s1 new, s2 old) so pin-to-request stays at 3 CE_R.
  logic       nmi_set, nmi_clr, ack_clr;
  logic [7:0] irq_set, irq_clr;

  assign nmi_set = icr_nmie ? (nmi_s1 & ~nmi_s2) : (nmi_s2 & ~nmi_s1);
  assign irq_set = irq_s2 & ~irq_s1 & icr_irqs;
  assign ack_clr = (state == S_PEND) && INT_ACK;
  assign nmi_clr = ack_clr && (pend_idx == 5'd0);

  always_comb begin
    irq_clr = 8'h00;
    for (int n = 0; n < 8; n++)
      irq_clr[n] = ack_clr && (pend_idx == 5'(n + 1));
  end

  // Source table in tie-break order: NMI, IRQ0..7, ONCHIP0..11.
  logic [NSRC-1:0] src_act;
  logic [4:0]      src_lvl [NSRC];
  logic [7:0]      src_vec [NSRC];
  logic [31:0]     irq_ipr, onc_ipr;

  assign irq_ipr = {ipra, iprb};
  assign onc_ipr = {iprc, iprd};

  always_comb begin
    src_act    = '0;
    src_act[0] = nmi_lat;
    src_lvl[0] = 5'd16;
    src_vec[0] = 8'd11;
    for (int n = 0; n < 8; n++) begin
      src_act[1+n] = icr_irqs[n] ? irq_lat[n] : ~irq_s2[n];
      src_lvl[1+n] = {1'b0, irq_ipr[31-4*n -: 4]};
      src_vec[1+n] = 8'(64 + n);
    end
    for (int i = 0; i < 8; i++) begin
      src_act[9+i] = ONCHIP_IRQ[i];
      src_lvl[9+i] = {1'b0, onc_ipr[31-4*i -: 4]};
      src_vec[9+i] = 8'(72 + 4*i);
    end
    src_act[17] = ONCHIP_IRQ[8];
    src_lvl[17] = {1'b0, ipre_hi[11:8]};
    src_vec[17] = 8'd104;
    src_act[18] = ONCHIP_IRQ[9];
    src_lvl[18] = {1'b0, ipre_hi[7:4]};
    src_vec[18] = 8'd108;
    src_act[19] = ONCHIP_IRQ[10];
    src_lvl[19] = {1'b0, ipre_hi[3:0]};
    src_vec[19] = 8'd112;
    src_act[20] = ONCHIP_IRQ[11];
    src_lvl[20] = {1'b0, ipre_hi[3:0]};
    src_vec[20] = 8'd113;
  end

  logic       win_ok, req_c;
  logic [4:0] win_lvl, win_idx;
  logic [7:0] win_vec;

  always_comb begin
    win_ok  = 1'b0;
    win_lvl = 5'd0;
    win_vec = 8'd0;
    win_idx = 5'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_act[k] && (src_lvl[k] > win_lvl)) begin
        win_ok  = 1'b1;
        win_lvl = src_lvl[k];
        win_vec = src_vec[k];
        win_idx = 5'(k);
      end
    end
  end

  assign req_c = win_ok && ((win_lvl > {1'b0, CPU_IMASK}) || (win_idx == 5'd0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      ipra         <= 16'h0;
      iprb         <= 16'h0;
      iprc         <= 16'h0;
      iprd         <= 16'h0;
      ipre_hi      <= 12'h0;
      icr_nmie     <= 1'b0;
      icr_irqs     <= 8'h00;
      nmi_s1       <= 1'b1;
      nmi_s2       <= 1'b1;
      nmi_lat      <= 1'b0;
      irq_s1       <= 8'hFF;
      irq_s2       <= 8'hFF;
      irq_lat      <= 8'h00;
      pend_idx     <= 5'd0;
      INT_REQ      <= 1'b0;
      INT_LVL      <= 4'd0;
      INT_VEC      <= 8'd0;
      ibus.IBUS_DO <= 32'h0;
    end else if (CE_R && !RES_N) begin
      state        <= S_IDLE;
      ipra         <= 16'h0;
      iprb         <= 16'h0;
      iprc         <= 16'h0;
      iprd         <= 16'h0;
      ipre_hi      <= 12'h0;
      icr_nmie     <= 1'b0;
      icr_irqs     <= 8'h00;
      nmi_s1       <= 1'b1;
      nmi_s2       <= 1'b1;
      nmi_lat      <= 1'b0;
      irq_s1       <= 8'hFF;
      irq_s2       <= 8'hFF;
      irq_lat      <= 8'h00;
      pend_idx     <= 5'd0;
      INT_REQ      <= 1'b0;
      INT_LVL      <= 4'd0;
      INT_VEC      <= 8'd0;
      ibus.IBUS_DO <= 32'h0;
    end else begin
      if (CE_R) begin
        nmi_s1  <= NMI_N;
        nmi_s2  <= nmi_s1;
        irq_s1  <= IRQ_N;
        irq_s2  <= irq_s1;
        // A fresh edge in the ack cycle keeps the latch set.
        nmi_lat <= (nmi_lat & ~nmi_clr) | nmi_set;
        irq_lat <= (irq_lat & ~irq_clr) | irq_set;

        if (wr) begin
          case (ibus.IBUS_A[3:2])
            2'b01: begin
              ipra <= lane_merge(ipra, ibus.IBUS_DI[31:16], hi_be);
              iprb <= lane_merge(iprb, ibus.IBUS_DI[15:0], lo_be);
            end
            2'b10: begin
              iprc <= lane_merge(iprc, ibus.IBUS_DI[31:16], hi_be);
              iprd <= lane_merge(iprd, ibus.IBUS_DI[15:0], lo_be);
            end
            2'b11: begin
              if (hi_be[1]) ipre_hi[11:4] <= ibus.IBUS_DI[31:24];
              if (hi_be[0]) ipre_hi[3:0]  <= ibus.IBUS_DI[23:20];
              if (lo_be[1]) icr_nmie      <= ibus.IBUS_DI[8];
              if (lo_be[0] && EDGE_EN) icr_irqs <= ibus.IBUS_DI[7:0];
            end
            default: ;
          endcase
        end

        case (state)
          S_IDLE, S_PEND: begin
            if (ack_clr) begin
              state   <= S_ACKW;
              INT_REQ <= 1'b0;
              INT_LVL <= 4'd0;
              INT_VEC <= 8'd0;
            end else if (req_c) begin
              state    <= S_PEND;
              INT_REQ  <= 1'b1;
              INT_LVL  <= win_lvl[4] ? 4'hF : win_lvl[3:0];
              INT_VEC  <= win_vec;
              pend_idx <= win_idx;
            end else begin
              state   <= S_IDLE;
              INT_REQ <= 1'b0;
              INT_LVL <= 4'd0;
              INT_VEC <= 8'd0;
            end
          end
          default: begin
            state   <= S_IDLE;
            INT_REQ <= 1'b0;
            INT_LVL <= 4'd0;
            INT_VEC <= 8'd0;
          end
        endcase
      end

      if (CE_F)
        ibus.IBUS_DO <= (sel && !ibus.IBUS_WE) ? rd_word : 32'h0;
    end
  end

endmodule

// File: tb/tb_sh7034_intc.sv
// tb/tb_sh7034_intc.sv - scoreboard bench for sh7034_intc
module tb_sh7034_intc;
  logic        CLK, RST, CE_R, CE_F, RES_N, NMI_N, INT_ACK;
  logic [7:0]  IRQ_N;
  logic [11:0] ONCHIP_IRQ;
  logic [3:0]  CPU_IMASK;
  logic        INT_REQ;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;

  sh7034_intc_if bus();

  sh7034_intc dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .NMI_N(NMI_N), .IRQ_N(IRQ_N), .ONCHIP_IRQ(ONCHIP_IRQ), .CPU_IMASK(CPU_IMASK),
    .INT_ACK(INT_ACK), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
    .ibus(bus)
  );

  typedef struct {
    logic       req;
    logic [3:0] lvl;
    logic [7:0] vec;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] dq[$];
  int          total = 0;
  int          bad = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    CE_R = 1'b0;
    CE_F = 1'b0;
    forever begin
      @(negedge CLK);
      CE_R = ~CE_R;
      CE_F = ~CE_R;
    end
  end

  task automatic tick_r();
    do @(posedge CLK); while (CE_R !== 1'b1);
    #1;
  endtask

  task automatic tick_f();
    do @(posedge CLK); while (CE_F !== 1'b1);
    #1;
  endtask

  task automatic bus_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.IBUS_A = a; bus.IBUS_DI = d; bus.IBUS_BA = be;
    bus.IBUS_WE = 1'b1; bus.IBUS_REQ = 1'b1;
    tick_r();
    bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b0;
  endtask

  task automatic bus_read(input logic [27:0] a, output logic [31:0] d);
    bus.IBUS_A = a; bus.IBUS_BA = 4'hF; bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b1;
    tick_f();
    d = bus.IBUS_DO;
    bus.IBUS_REQ = 1'b0;
  endtask

  task automatic hw_reset();
    NMI_N = 1'b1; IRQ_N = 8'hFF; ONCHIP_IRQ = 12'h0; CPU_IMASK = 4'd0;
    INT_ACK = 1'b0; RES_N = 1'b1;
    bus.IBUS_A = 28'h0; bus.IBUS_DI = 32'h0; bus.IBUS_BA = 4'h0;
    bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] d, x;
    NMI_N = 1'b1; IRQ_N = 8'hFF; ONCHIP_IRQ = 12'h0; CPU_IMASK = 4'd0;
    INT_ACK = 1'b0; RES_N = 1'b1;
    bus.IBUS_A = 28'h0; bus.IBUS_DI = 32'h0; bus.IBUS_BA = 4'h0;
    bus.IBUS_WE = 1'b0; bus.IBUS_REQ = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL reset_out got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    total++;
    if (bus.IBUS_DO !== 32'h0) begin bad++; $display("FAIL reset_do got=%h exp=0", bus.IBUS_DO); end
    RST = 1'b0;

    bus.IBUS_REQ = 1'b1;
    bus.IBUS_A = 28'h5FFFF80; #1; total++;
    if (bus.IBUS_ACT !== 1'b0) begin bad++; $display("FAIL act_80 got=%b exp=0", bus.IBUS_ACT); end
    bus.IBUS_A = 28'h5FFFF8F; #1; total++;
    if (bus.IBUS_ACT !== 1'b1) begin bad++; $display("FAIL act_8f got=%b exp=1", bus.IBUS_ACT); end
    bus.IBUS_A = 28'h5FFFF90; #1; total++;
    if (bus.IBUS_ACT !== 1'b0) begin bad++; $display("FAIL act_90 got=%b exp=0", bus.IBUS_ACT); end
    bus.IBUS_REQ = 1'b0;

    dq.push_back(32'h0000_0000);
    dq.push_back(32'h0000_8000);
    bus_read(28'h5FFFF84, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL reset_ipra got=%h exp=%h", d, x); end
    bus_read(28'h5FFFF8C, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL reset_icr got=%h exp=%h", d, x); end
  endtask

  task automatic test_onchip();
    exp_t e;
    logic [31:0] d, x;
    bus_write(28'h5FFFF88, 32'h5000_0000, 4'b1100);
    ONCHIP_IRQ[0] = 1'b1; CPU_IMASK = 4'd4;
    sq.push_back('{1'b1, 4'd5, 8'd72});
    tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL onchip0 got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    dq.push_back(32'h5000_0000);
    bus_read(28'h5FFFF88, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL iprc_rd got=%h exp=%h", d, x); end
    tick_f(); total++;
    if (bus.IBUS_DO !== 32'h0) begin bad++; $display("FAIL do_unsel got=%h exp=0", bus.IBUS_DO); end
    CPU_IMASK = 4'd5;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL mask_eq got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
  endtask

  task automatic test_tie();
    exp_t e;
    bus_write(28'h5FFFF8C, 32'h00A0_0000, 4'b1100);
    bus_write(28'h5FFFF84, 32'hA000_0000, 4'b1100);
    CPU_IMASK = 4'd0; ONCHIP_IRQ[10] = 1'b1; IRQ_N = 8'hFE;
    sq.push_back('{1'b1, 4'd10, 8'd64});
    repeat (3) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL tie_irq0 got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    IRQ_N = 8'hFF;
    sq.push_back('{1'b1, 4'd10, 8'd112});
    repeat (3) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL tie_wdt got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
  endtask

  task automatic test_nmi();
    exp_t e;
    CPU_IMASK = 4'd15; NMI_N = 1'b0;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    sq.push_back('{1'b1, 4'd15, 8'd11});
    repeat (2) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmi_early got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmi_req got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    INT_ACK = 1'b1;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    tick_r();
    INT_ACK = 1'b0;
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmi_ack got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    sq.push_back('{1'b0, 4'd0, 8'd0});
    repeat (3) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmi_cleared got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
  endtask

  task automatic test_nmie();
    exp_t e;
    logic [31:0] d, x;
    bus_write(28'h5FFFF8E, 32'h0000_0100, 4'b0011);
    CPU_IMASK = 4'd15; NMI_N = 1'b0;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    repeat (3) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmie_fall got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    NMI_N = 1'b1;
    sq.push_back('{1'b1, 4'd15, 8'd11});
    repeat (3) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL nmie_rise got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    dq.push_back(32'h0000_8100);
    bus_read(28'h5FFFF8E, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL icr_nmie_rd got=%h exp=%h", d, x); end
  endtask

  task automatic test_irq_edge();
    exp_t e;
    logic [31:0] d, x;
    bus_write(28'h5FFFF8E, 32'h0000_0001, 4'b0011);
    bus_write(28'h5FFFF84, 32'h3000_0000, 4'b1100);
    CPU_IMASK = 4'd0;
`ifdef SH7034_INTC_EDGE_EN
    dq.push_back(32'h0000_8001);
    sq.push_back('{1'b1, 4'd3, 8'd64});
`else
    dq.push_back(32'h0000_8000);
    sq.push_back('{1'b0, 4'd0, 8'd0});
`endif
    bus_read(28'h5FFFF8E, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL icr_irqs_rd got=%h exp=%h", d, x); end
    IRQ_N = 8'hFE;
    tick_r();
    IRQ_N = 8'hFF;
    repeat (5) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL irq_edge_hold got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    INT_ACK = 1'b1;
    tick_r();
    INT_ACK = 1'b0;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    repeat (2) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL irq_edge_ack got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
  endtask

  task automatic test_iprb_res();
    exp_t e;
    logic [31:0] d, x;
    IRQ_N = 8'hEF; CPU_IMASK = 4'd0;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    repeat (4) tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL iprb_zero got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    sq.push_back('{1'b0, 4'd0, 8'd0});
    sq.push_back('{1'b1, 4'd7, 8'd68});
    bus_write(28'h5FFFF86, 32'h0000_7000, 4'b0011);
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL iprb_wr_cycle got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    tick_r();
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL iprb_next got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    RES_N = 1'b0;
    sq.push_back('{1'b0, 4'd0, 8'd0});
    tick_r();
    RES_N = 1'b1;
    e = sq.pop_front(); total++;
    if ({INT_REQ, INT_LVL, INT_VEC} !== {e.req, e.lvl, e.vec}) begin
      bad++; $display("FAIL res_n_out got=%h exp=%h", {INT_REQ, INT_LVL, INT_VEC}, {e.req, e.lvl, e.vec});
    end
    dq.push_back(32'h0000_0000);
    bus_read(28'h5FFFF86, d);
    x = dq.pop_front(); total++;
    if (d !== x) begin bad++; $display("FAIL res_n_iprb got=%h exp=%h", d, x); end
  endtask

  initial begin
    test_reset();
    test_onchip();
    hw_reset();
    test_tie();
    hw_reset();
    test_nmi();
    hw_reset();
    test_nmie();
    hw_reset();
    test_irq_edge();
    hw_reset();
    test_iprb_res();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
